uart_rx_axi_lite: RTL and testbench

//   AXI4-Lite UART receiver peripheral, the RX counterpart of the uart_tx_v1_0 IP. It deserialises the rx pin

---
 rtl/uart_rx_axi_lite.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_rx_axi_lite.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axi_lite.sv
// AXI4-Lite UART receiver: rx deserialiser, RX FIFO, CONFIG/STATUS map.
// Level interrupt on data available or sticky error.
module uart_rx_axi_lite #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int DEFAULT_DIVISOR    = 868
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic                            rx,
  output logic                            interrupt,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PAR = 3'd3, S_STOP1 = 3'd4, S_STOP2 = 3'd5,
                         S_HOLD = 3'd6;

  logic clk, rst_n;
  assign clk   = s_axi_aclk;
  assign rst_n = s_axi_aresetn;

  logic        awready_q, bvalid_q, arready_q, rvalid_q, irq_q;
  logic [1:0]  bresp_q, rresp_q, rresp_d;
  logic [31:0] rdata_q, rd_val, status;
  logic [5:0]  fmt_q;
  logic [15:0] div_q;
  logic        aw_hs, ar_hs, clr, pop, st_rd;
  logic [1:0]  waddr, raddr;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          empty, full, push_ok, ovr_q, pe_s_q, fe_s_q;

  logic        rx1_q, rx2_q, rxp_q, fall;
  logic [2:0]  st_q, st_d, idx_q, idx_d;
  logic [15:0] cnt_bit_q, cnt_bit_d, sdiv_q, sdiv_d;
  logic [3:0]  sfmt_q, sfmt_d;
  logic [7:0]  dat_q, dat_d;
  logic        par_q, par_d, pe_q, pe_d, fe_q, fe_d;
  logic        push, set_pe, set_fe, tick;
  logic [9:0]  push_data;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                       s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4],
                       s_axi_awaddr[1:0], s_axi_wdata[15:7],
                       s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4],
                       s_axi_araddr[1:0]};

  assign waddr = s_axi_awaddr[3:2];
  assign raddr = s_axi_araddr[3:2];
  assign aw_hs = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign ar_hs = arready_q & s_axi_arvalid;
  assign clr   = aw_hs & (waddr == 2'd1) & s_axi_wdata[6];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = ar_hs & (raddr == 2'd0) & !empty;
  assign st_rd = ar_hs & (raddr == 2'd2);
  // Pop frees the slot first, so a full FIFO still takes a same-cycle push
  assign push_ok = push & !clr & (!full | pop);

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign interrupt     = irq_q;

  assign status = {19'b0, 5'(cnt_q), 2'b0, (st_q != S_IDLE),
                   fe_s_q, pe_s_q, ovr_q, full, empty};

  always_comb begin
    rd_val  = '0;
    rresp_d = 2'b00;
    case (raddr)
      2'd0: if (!empty) rd_val = {1'b1, 21'b0, mem_q[rp_q]};
      2'd1: rd_val = {div_q, 10'b0, fmt_q};
      2'd2: rd_val = status;
      default: rresp_d = 2'b10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      fmt_q     <= '0;
      div_q     <= 16'(DEFAULT_DIVISOR);
      irq_q     <= 1'b0;
    end else begin
      awready_q <= s_axi_awvalid & s_axi_wvalid & !bvalid_q & !awready_q;
      arready_q <= s_axi_arvalid & !rvalid_q & !arready_q;
      if (aw_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (waddr == 2'd3) ? 2'b10 : 2'b00;
      end else if (bvalid_q & s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (aw_hs && waddr == 2'd1) begin
        fmt_q <= s_axi_wdata[5:0];
        div_q <= (s_axi_wdata[31:16] < 16'd4) ? 16'd4 : s_axi_wdata[31:16];
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rresp_d;
      end else if (rvalid_q & s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      irq_q <= (fmt_q[4] & !empty) | (fmt_q[5] & (ovr_q | pe_s_q | fe_s_q));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      pe_s_q <= 1'b0;
      fe_s_q <= 1'b0;
    end else begin
      if (clr) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (pop) rp_q <= rp_q + 1'b1;
        if (push_ok) wp_q <= wp_q + 1'b1;
        cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
      end
      if (st_rd) begin
        ovr_q  <= 1'b0;
        pe_s_q <= 1'b0;
        fe_s_q <= 1'b0;
      end
      if (push & !clr & full & !pop) ovr_q <= 1'b1;
      if (set_pe) pe_s_q <= 1'b1;
      if (set_fe) fe_s_q <= 1'b1;
    end
  end

  // Sync chain resets low so a line held low out of reset is not an edge
  assign fall = rxp_q & !rx2_q;
  assign tick = (cnt_bit_q == 16'd0);

  always_comb begin
    st_d      = st_q;
    cnt_bit_d = cnt_bit_q;
    idx_d     = idx_q;
    dat_d     = dat_q;
    par_d     = par_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    sdiv_d    = sdiv_q;
    sfmt_d    = sfmt_q;
    push      = 1'b0;
    set_pe    = 1'b0;
    set_fe    = 1'b0;
    if (st_q != S_IDLE && st_q != S_HOLD)
      cnt_bit_d = tick ? sdiv_q - 16'd1 : cnt_bit_q - 16'd1;
    case (st_q)
      S_IDLE: if (fall) begin
        st_d      = S_START;
        sdiv_d    = div_q;
        sfmt_d    = fmt_q[3:0];
        cnt_bit_d = (div_q >> 1) - 16'd1;
        idx_d     = '0;
        dat_d     = '0;
        par_d     = 1'b0;
        pe_d      = 1'b0;
        fe_d      = 1'b0;
      end
      S_START: if (tick) st_d = rx2_q ? S_IDLE : S_DATA;
      S_DATA: if (tick) begin
        dat_d[idx_q] = rx2_q;
        par_d        = par_q ^ rx2_q;
        idx_d        = idx_q + 3'd1;
        if (idx_q == (sfmt_q[3] ? 3'd6 : 3'd7))
          st_d = sfmt_q[0] ? S_PAR : S_STOP1;
      end
      S_PAR: if (tick) begin
        if ((par_q ^ rx2_q) != sfmt_q[1]) begin
          pe_d   = 1'b1;
          set_pe = 1'b1;
        end
        st_d = S_STOP1;
      end
      S_STOP1, S_STOP2: if (tick) begin
        if (!rx2_q) begin
          fe_d   = 1'b1;
          set_fe = 1'b1;
        end
        if (st_q == S_STOP1 && sfmt_q[2]) begin
          st_d = S_STOP2;
        end else begin
          push = 1'b1;
          st_d = rx2_q ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: if (rx2_q) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign push_data = {fe_d, pe_d, dat_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx1_q     <= 1'b0;
      rx2_q     <= 1'b0;
      rxp_q     <= 1'b0;
      st_q      <= S_IDLE;
      cnt_bit_q <= '0;
      idx_q     <= '0;
      dat_q     <= '0;
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      sdiv_q    <= '0;
      sfmt_q    <= '0;
    end else begin
      rx1_q     <= rx;
      rx2_q     <= rx1_q;
      rxp_q     <= rx2_q;
      st_q      <= st_d;
      cnt_bit_q <= cnt_bit_d;
      idx_q     <= idx_d;
      dat_q     <= dat_d;
      par_q     <= par_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      sdiv_q    <= sdiv_d;
      sfmt_q    <= sfmt_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_axi_lite.sv
// Directed bench for uart_rx_axi_lite: frames driven on rx,
// results read back over AXI4-Lite and checked against hand values.
module tb_uart_rx_axi_lite;
  localparam int BITC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0;
  logic        irq;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awvalid = 0, awready, wvalid = 0, wready;
  logic        bvalid, bready = 0, arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic [1:0]  rsp;
  logic        irq_at_hs;

  always #5 clk = ~clk;

  uart_rx_axi_lite dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .rx(rx), .interrupt(irq),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin cyc(1); n++; end
    chk("awready_seen", {31'b0, awready}, 32'd1);
    cyc(1);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin cyc(1); n++; end
    chk("bvalid_seen", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    bready = 1;
    cyc(1);
    bready = 0;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin cyc(1); n++; end
    chk("arready_seen", {31'b0, arready}, 32'd1);
    cyc(1);
    arvalid = 0;
    irq_at_hs = irq;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin cyc(1); n++; end
    chk("rvalid_seen", {31'b0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    rready = 1;
    cyc(1);
    rready = 0;
  endtask

  task automatic send(input logic [7:0] d, input int nd, input bit pen,
                      input bit pbit, input int ns, input bit sv);
    rx = 0; cyc(BITC);
    for (int i = 0; i < nd; i++) begin rx = d[i]; cyc(BITC); end
    if (pen) begin rx = pbit; cyc(BITC); end
    for (int i = 0; i < ns; i++) begin rx = sv; cyc(BITC); end
    if (sv) cyc(2);
  endtask

  initial begin
    cyc(3);
    rst_n = 1;
    cyc(2);
    chk("irq_reset", {31'b0, irq}, 32'd0);
    axi_rd(32'h8, rd, rsp);
    chk("status_reset", rd, 32'h0000_0001);
    axi_rd(32'h4, rd, rsp);
    chk("config_reset", rd, 32'h0364_0000);
    cyc(30);
    axi_rd(32'h8, rd, rsp);
    chk("low_line_no_start", rd, 32'h0000_0001);
    rx = 1;
    cyc(10);

    axi_wr(32'h4, 32'h0010_0000, rsp);
    chk("cfg_bresp", {30'b0, rsp}, 32'd0);
    send(8'hA5, 8, 0, 0, 1, 1);
    axi_rd(32'h8, rd, rsp);
    chk("t1_status", rd, 32'h0000_0100);
    axi_rd(32'h0, rd, rsp);
    chk("t1_buff", rd, 32'h8000_00A5);
    axi_rd(32'h0, rd, rsp);
    chk("t1_empty_read", rd, 32'h0);
    axi_rd(32'h8, rd, rsp);
    chk("t1_status_empty", rd, 32'h0000_0001);

    axi_wr(32'h4, 32'h0010_0007, rsp);
    send(8'h3C, 8, 1, 1, 2, 1);
    axi_rd(32'h0, rd, rsp);
    chk("t2_good_parity", rd, 32'h8000_003C);
    send(8'h3C, 8, 1, 0, 2, 1);
    axi_rd(32'h0, rd, rsp);
    chk("t2_bad_parity", rd, 32'h8000_013C);
    axi_rd(32'h8, rd, rsp);
    chk("t2_status_pe", rd, 32'h0000_0009);
    axi_rd(32'h8, rd, rsp);
    chk("t2_status_clr", rd, 32'h0000_0001);

    axi_wr(32'h4, 32'h0010_0000, rsp);
    for (int i = 0; i < 17; i++) send(8'(i), 8, 0, 0, 1, 1);
    axi_rd(32'h8, rd, rsp);
    chk("t3_full_ovr", rd, 32'h0000_1006);
    for (int i = 0; i < 16; i++) begin
      axi_rd(32'h0, rd, rsp);
      chk("t3_order", rd, 32'h8000_0000 | 32'(i));
    end
    axi_rd(32'h8, rd, rsp);
    chk("t3_drained", rd, 32'h0000_0001);

    send(8'h55, 8, 0, 0, 1, 0);
    cyc(40);
    axi_rd(32'h8, rd, rsp);
    chk("t4_busy_fe", rd, 32'h0000_0130);
    rx = 1;
    cyc(10);
    axi_rd(32'h8, rd, rsp);
    chk("t4_idle", rd, 32'h0000_0100);
    axi_rd(32'h0, rd, rsp);
    chk("t4_buff", rd, 32'h8000_0255);

    axi_wr(32'h4, 32'h0010_0010, rsp);
    cyc(2);
    chk("t5_irq_idle", {31'b0, irq}, 32'd0);
    send(8'h5A, 8, 0, 0, 1, 1);
    chk("t5_irq_rise", {31'b0, irq}, 32'd1);
    axi_rd(32'h0, rd, rsp);
    chk("t5_buff", rd, 32'h8000_005A);
    chk("t5_irq_at_pop", {31'b0, irq_at_hs}, 32'd1);
    chk("t5_irq_fall", {31'b0, irq}, 32'd0);
    rx = 0; cyc(3); rx = 1;
    cyc(20);
    axi_rd(32'h8, rd, rsp);
    chk("t5_glitch", rd, 32'h0000_0001);

    axi_wr(32'h4, 32'h0010_0000, rsp);
    send(8'h11, 8, 0, 0, 1, 1);
    send(8'h22, 8, 0, 0, 1, 1);
    send(8'h33, 8, 0, 0, 1, 0);
    rx = 1;
    cyc(BITC);
    axi_wr(32'h4, 32'h0010_0040, rsp);
    axi_rd(32'h8, rd, rsp);
    chk("t6_cleared", rd, 32'h0000_0011);
    axi_rd(32'h4, rd, rsp);
    chk("t6_clrbuf_reads0", rd, 32'h0010_0000);
    axi_rd(32'hC, rd, rsp);
    chk("t6_badaddr_rresp", {30'b0, rsp}, 32'd2);
    chk("t6_badaddr_rdata", rd, 32'h0);
    axi_wr(32'hC, 32'h0, rsp);
    chk("t6_badaddr_bresp", {30'b0, rsp}, 32'd2);
    axi_wr(32'h8, 32'hFFFF_FFFF, rsp);
    chk("t6_ro_bresp", {30'b0, rsp}, 32'd0);

    send(8'h44, 8, 0, 0, 1, 0);
    rx = 1;
    cyc(BITC);
    axi_rd(32'h0, rd, rsp);
    chk("err_entry", rd, 32'h8000_0244);
    axi_wr(32'h4, 32'h0010_0020, rsp);
    cyc(2);
    chk("ie_err_irq", {31'b0, irq}, 32'd1);
    axi_rd(32'h8, rd, rsp);
    chk("ie_err_status", rd, 32'h0000_0011);
    chk("ie_err_irq_clr", {31'b0, irq}, 32'd0);

    axi_wr(32'h4, 32'h0001_0000, rsp);
    axi_rd(32'h4, rd, rsp);
    chk("div_clamp", rd, 32'h0004_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
